pal_cfg_loader: RTL and testbench

//  Upstream feeder for the PAL fabric configuration chain. Accepts a framed byte stream
//  (header, payload, XOR checksum) on a valid/ready port and serializes the payload
//  MSB-first into the PAL's 1-bit cfg input, one bit per clock, with a shift strobe.

---
 rtl/pal_cfg_loader.sv | 107 ++++++++++
 tb/tb_pal_cfg_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pal_cfg_loader.sv
// Framed byte-stream loader for the PAL configuration chain: strips the header,
// serializes the payload MSB-first with a shift strobe, and verifies an XOR checksum.
module pal_cfg_loader #(
    parameter int          CFG_BITS = 264,
    parameter logic [7:0]  HDR      = 8'hA5
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       abort,
    output logic       pal_cfg,
    output logic       pal_shift_en,
    output logic       busy,
    output logic       cfg_ok,
    output logic       cfg_err
);
    // state | meaning
    // IDLE  | hunting for the header byte, flags hold the last frame result
    // LOAD  | waiting for the next payload byte
    // SHIFT | streaming one byte into the PAL chain, one bit per clock
    // CHECK | waiting for the checksum byte

    localparam int NBYTES = (CFG_BITS + 7) / 8;
    localparam int REM    = CFG_BITS - 8 * (NBYTES - 1);
    localparam int BCW    = $clog2(NBYTES + 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);
    localparam logic [3:0]     REM_M1    = 4'(REM - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, CHECK} state_t;

    state_t         state;
    logic [7:0]     shreg;
    logic [7:0]     csum;
    logic [BCW-1:0] byte_cnt;
    logic [3:0]     bit_cnt;
    logic           accept;

    assign in_ready = res_n && (state != SHIFT);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state        <= IDLE;
            shreg        <= '0;
            csum         <= '0;
            byte_cnt     <= '0;
            bit_cnt      <= '0;
            pal_cfg      <= 1'b0;
            pal_shift_en <= 1'b0;
            cfg_ok       <= 1'b0;
            cfg_err      <= 1'b0;
        end else if (abort) begin
            state        <= IDLE;
            pal_cfg      <= 1'b0;
            pal_shift_en <= 1'b0;
            cfg_ok       <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && in_data == HDR) begin
                        state    <= LOAD;
                        cfg_ok   <= 1'b0;
                        cfg_err  <= 1'b0;
                        csum     <= '0;
                        byte_cnt <= '0;
                    end
                end
                LOAD: begin
                    // First bit goes out on the accepting edge; bit_cnt holds bits still to follow.
                    if (accept) begin
                        shreg        <= {in_data[6:0], 1'b0};
                        pal_cfg      <= in_data[7];
                        pal_shift_en <= 1'b1;
                        csum         <= csum ^ in_data;
                        bit_cnt      <= (byte_cnt == LAST_BYTE) ? REM_M1 : 4'd7;
                        state        <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_cnt == 4'd0) begin
                        pal_cfg      <= 1'b0;
                        pal_shift_en <= 1'b0;
                        byte_cnt     <= byte_cnt + 1'b1;
                        state        <= (byte_cnt == LAST_BYTE) ? CHECK : LOAD;
                    end else begin
                        pal_cfg <= shreg[7];
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                CHECK: begin
                    if (accept) begin
                        cfg_ok  <= (in_data == csum);
                        cfg_err <= (in_data != csum);
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Directed + randomized bench for pal_cfg_loader with a frame-level reference model.
module tb_pal_cfg_loader;
    logic       clk = 1'b0;
    logic       res_n;
    logic [7:0] in_data;
    logic       vld;
    logic       sel;
    logic       abort;

    logic in_valid_a, in_ready_a, pal_cfg_a, pal_shift_en_a, busy_a, cfg_ok_a, cfg_err_a;
    logic in_valid_b, in_ready_b, pal_cfg_b, pal_shift_en_b, busy_b, cfg_ok_b, cfg_err_b;
    logic rdy;

    int checks = 0;
    int errors = 0;
    int overlap = 0;

    logic [7:0] frame_q[$];
    bit         mon_a[$];
    bit         mon_b[$];

    assign in_valid_a = vld & ~sel;
    assign in_valid_b = vld & sel;
    assign rdy        = sel ? in_ready_b : in_ready_a;

    always #5 clk = ~clk;

    pal_cfg_loader #(.CFG_BITS(264), .HDR(8'hA5)) dut_a (
        .clk(clk), .res_n(res_n), .in_data(in_data), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .abort(abort), .pal_cfg(pal_cfg_a),
        .pal_shift_en(pal_shift_en_a), .busy(busy_a), .cfg_ok(cfg_ok_a), .cfg_err(cfg_err_a)
    );

    pal_cfg_loader #(.CFG_BITS(20), .HDR(8'hA5)) dut_b (
        .clk(clk), .res_n(res_n), .in_data(in_data), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .abort(abort), .pal_cfg(pal_cfg_b),
        .pal_shift_en(pal_shift_en_b), .busy(busy_b), .cfg_ok(cfg_ok_b), .cfg_err(cfg_err_b)
    );

    // Capture every strobed bit; ready must never coincide with a strobe.
    always @(negedge clk) begin
        if (res_n) begin
            if (pal_shift_en_a) mon_a.push_back(pal_cfg_a);
            if (pal_shift_en_b) mon_b.push_back(pal_cfg_b);
            if ((in_ready_a && pal_shift_en_a) || (in_ready_b && pal_shift_en_b)) overlap++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int first_mismatch(input bit to_b, input int n);
        int sz;
        bit got;
        sz = to_b ? mon_b.size() : mon_a.size();
        for (int i = 0; i < n; i++) begin
            if (i >= sz) return i;
            got = to_b ? mon_b[i] : mon_a[i];
            if (got != frame_q[i / 8][7 - (i % 8)]) return i;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_xor();
        logic [7:0] x = 8'h00;
        foreach (frame_q[i]) x ^= frame_q[i];
        return x;
    endfunction

    task automatic send_byte(input logic [7:0] d, input bit gaps);
        int n = 0;
        if (gaps) begin
            vld = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        in_data = d;
        vld     = 1'b1;
        while (!rdy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!rdy) begin
            checks++;
            errors++;
            $error("FAIL send_timeout observed=ready_low expected=ready_high byte=%0h", d);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        vld = 1'b0;
    endtask

    task automatic do_frame(input bit to_b, input logic [7:0] chk, input bit gaps, input string tag);
        int  nbits;
        bit  exp_ok;
        nbits  = to_b ? 20 : 264;
        exp_ok = (model_xor() == chk);
        sel    = to_b;
        if (to_b) mon_b.delete(); else mon_a.delete();
        send_byte(8'hA5, gaps);
        foreach (frame_q[i]) send_byte(frame_q[i], gaps);
        send_byte(chk, gaps);
        #1;
        check({tag, "_strobes"}, to_b ? mon_b.size() : mon_a.size(), nbits);
        check({tag, "_order"}, first_mismatch(to_b, nbits), -1);
        check({tag, "_ok"},  to_b ? cfg_ok_b  : cfg_ok_a,  exp_ok);
        check({tag, "_err"}, to_b ? cfg_err_b : cfg_err_a, !exp_ok);
    endtask

    initial begin
        res_n   = 1'b0;
        vld     = 1'b1;
        sel     = 1'b0;
        in_data = 8'h00;
        abort   = 1'b0;

        #12;
        check("rst_ready", in_ready_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_shift", pal_shift_en_a, 0);
        check("rst_cfg", pal_cfg_a, 0);
        check("rst_flags", {cfg_ok_a, cfg_err_a, cfg_ok_b, cfg_err_b}, 0);
        @(negedge clk);
        res_n = 1'b1;
        #1;
        check("rel_ready", in_ready_a, 1);
        check("rel_busy", busy_a, 0);
        vld = 1'b0;
        @(negedge clk);

        // Good 264-bit frame with an incrementing payload.
        frame_q.delete();
        for (int i = 0; i < 33; i++) frame_q.push_back(8'(i));
        do_frame(1'b0, 8'h20, 1'b0, "good264");
        check("good264_idle", busy_a, 0);

        // Bad checksum, then a new header clears the flags.
        do_frame(1'b0, 8'h21, 1'b0, "bad264");
        mon_a.delete();
        send_byte(8'hA5, 1'b0);
        #1;
        check("hdr_clr_ok", cfg_ok_a, 0);
        check("hdr_clr_err", cfg_err_a, 0);
        check("hdr_busy", busy_a, 1);

        // Abort after 5 strobes of payload byte 3, with in_valid held.
        frame_q.delete();
        for (int i = 0; i < 4; i++) frame_q.push_back(8'(i));
        for (int i = 0; i < 4; i++) send_byte(8'(i), 1'b0);
        repeat (4) @(negedge clk);
        #1;
        check("abort_pre_strobes", mon_a.size(), 29);
        abort   = 1'b1;
        vld     = 1'b1;
        in_data = 8'h04;
        @(negedge clk);
        #1;
        check("abort_shift", pal_shift_en_a, 0);
        check("abort_busy", busy_a, 0);
        check("abort_strobes", mon_a.size(), 29);
        check("abort_partial", first_mismatch(1'b0, 29), -1);
        abort = 1'b0;
        vld   = 1'b0;
        @(negedge clk);

        frame_q.delete();
        for (int i = 0; i < 33; i++) frame_q.push_back(8'(i));
        do_frame(1'b0, 8'h20, 1'b0, "after_abort");

        // Abort wins over a simultaneous header handshake in IDLE.
        in_data = 8'hA5;
        vld     = 1'b1;
        abort   = 1'b1;
        @(negedge clk);
        #1;
        check("prio_ok", cfg_ok_a, 0);
        check("prio_busy", busy_a, 0);
        abort = 1'b0;
        vld   = 1'b0;
        @(negedge clk);

        // Junk bytes are dropped, then a 20-bit frame with a partial last byte.
        sel = 1'b1;
        mon_b.delete();
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        #1;
        check("junk_strobes", mon_b.size(), 0);
        check("junk_busy", busy_b, 0);
        frame_q.delete();
        frame_q.push_back(8'hF0);
        frame_q.push_back(8'h0F);
        frame_q.push_back(8'hB7);
        do_frame(1'b1, 8'h48, 1'b0, "part20");
        check("part20_tail", {mon_b[16], mon_b[17], mon_b[18], mon_b[19]}, 4'b1011);

        // Random payloads under random backpressure, correct or corrupted checksums.
        for (int f = 0; f < 4; f++) begin
            logic [7:0] chk;
            bit         to_b;
            to_b = f[0];
            frame_q.delete();
            for (int i = 0; i < (to_b ? 3 : 33); i++) frame_q.push_back(8'($urandom));
            chk = ($urandom_range(0, 1) == 1) ? model_xor() : 8'($urandom);
            do_frame(to_b, chk, 1'b1, to_b ? "rand20" : "rand264");
        end

        check("ready_during_strobe", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
